// File: rtl/flattening_stream.sv
// flattening_stream
//
// Collects one frame of NumOfChannels images (ImageSize pixels each), arriving
// NumOfInputs channels per beat, into one of two banks. A full bank is then
// emitted as a flat vector in OutWidth-element beats. Flat element order is
// channel-major (Interleave=0) or pixel-major (Interleave=1). The last beat is
// zero-padded when the frame size is not a multiple of OutWidth. While one
// bank drains, the other bank can fill.
//
// Handshake: a beat moves on a port in any cycle where valid and ready are
// both high at the rising clock edge. A beat that is offered is held stable
// until it is taken. in_ready and out_valid come only from registers, so
// out_ready has no combinational path to in_ready.
//
// Ports:
//   clk, res     clock; asynchronous active-high reset
//   in_valid     input beat valid
//   in_start     first beat of a frame (qualified by in_valid)
//   in_data      one pixel per lane, lane l at [l*BitSize +: BitSize]
//   in_ready     the bank being written has room
//   out_valid    output beat valid (read bank is full)
//   out_ready    downstream accepts the beat
//   out_start    first output beat of a frame
//   out_last     last output beat of a frame
//   out_data     element j at [j*BitSize +: BitSize]; 0 when not valid
//   frame_abort  one-cycle pulse after a partial fill is discarded
module flattening_stream #(
  parameter int BitSize       = 2,
  parameter int ImageSize     = 9,
  parameter int NumOfChannels = 4,
  parameter int NumOfInputs   = 2,
  parameter int OutWidth      = 4,
  parameter int Interleave    = 0
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          in_valid,
  input  logic                          in_start,
  input  logic [NumOfInputs*BitSize-1:0] in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_start,
  output logic                          out_last,
  output logic [OutWidth*BitSize-1:0]   out_data,
  output logic                          frame_abort
);

  localparam int G   = NumOfChannels / NumOfInputs;
  localparam int N   = NumOfChannels * ImageSize;
  localparam int IB  = G * ImageSize;
  localparam int OB  = (N + OutWidth - 1) / OutWidth;
  localparam int AW  = (N > 1) ? $clog2(N) : 1;
  localparam int ICW = $clog2(IB + 1);
  localparam int OCW = $clog2(OB + 1);
  localparam int GW  = $clog2(G + 1);
  localparam int PW  = $clog2(ImageSize + 1);

  localparam logic [ICW-1:0] IB_LAST  = ICW'(IB - 1);
  localparam logic [OCW-1:0] OB_LAST  = OCW'(OB - 1);
  localparam logic [PW-1:0]  PIX_LAST = PW'(ImageSize - 1);

  logic [BitSize-1:0] bank [2][N];

  logic           wr_bank, rd_bank;
  logic [1:0]     bank_full, bank_full_next;
  logic [ICW-1:0] in_cnt, eff_cnt;
  // grp/pix track in_cnt split into channel group and pixel, to avoid a divider
  logic [GW-1:0]  grp, eff_grp;
  logic [PW-1:0]  pix, eff_pix;
  logic [OCW-1:0] out_cnt;
  logic           in_fire, out_fire, fill_done, drain_done, abort_now;
  logic [AW-1:0]  wr_idx [NumOfInputs];

  assign in_ready  = !bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];
  assign out_start = out_valid && (out_cnt == '0);
  assign out_last  = out_valid && (out_cnt == OB_LAST);

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign drain_done = out_fire && out_last;

  // in_start always restarts the frame at beat 0. When the fill was partial,
  // this discards it.
  assign eff_cnt   = in_start ? '0 : in_cnt;
  assign eff_grp   = in_start ? '0 : grp;
  assign eff_pix   = in_start ? '0 : pix;
  assign fill_done = in_fire && (eff_cnt == IB_LAST);
  assign abort_now = in_fire && in_start && (in_cnt != '0);

  // A fill and a drain can finish together. They always act on different
  // banks, so both updates apply.
  always_comb begin
    bank_full_next = bank_full;
    if (fill_done)  bank_full_next[wr_bank] = 1'b1;
    if (drain_done) bank_full_next[rd_bank] = 1'b0;
  end

  always_comb begin
    for (int l = 0; l < NumOfInputs; l++) begin
      if (Interleave != 0)
        wr_idx[l] = AW'(int'(eff_pix) * NumOfChannels + int'(eff_grp) * NumOfInputs + l);
      else
        wr_idx[l] = AW'((int'(eff_grp) * NumOfInputs + l) * ImageSize + int'(eff_pix));
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      bank_full   <= 2'b00;
      in_cnt      <= '0;
      grp         <= '0;
      pix         <= '0;
      out_cnt     <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= abort_now;
      bank_full   <= bank_full_next;
      if (in_fire) begin
        if (fill_done) begin
          in_cnt  <= '0;
          grp     <= '0;
          pix     <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          in_cnt <= eff_cnt + 1'b1;
          if (eff_pix == PIX_LAST) begin
            pix <= '0;
            grp <= eff_grp + 1'b1;
          end else begin
            pix <= eff_pix + 1'b1;
            grp <= eff_grp;
          end
        end
      end
      if (out_fire) begin
        if (out_last) begin
          out_cnt <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

  // Bank contents are not reset. Only data marked valid by bank_full is read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int l = 0; l < NumOfInputs; l++)
        bank[wr_bank][wr_idx[l]] <= in_data[l*BitSize +: BitSize];
    end
  end

  // Elements past the end of the frame are padded with 0.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < OutWidth; j++) begin
      if (out_valid && ((int'(out_cnt) * OutWidth + j) < N))
        out_data[j*BitSize +: BitSize] = bank[rd_bank][AW'(int'(out_cnt) * OutWidth + j)];
    end
  end

endmodule

// File: tb/tb_flattening_stream.sv
module tb_flattening_stream;
  localparam int BS  = 2;
  localparam int IS  = 9;
  localparam int NC  = 4;
  localparam int NI  = 2;
  localparam int OW  = 4;
  localparam int G   = NC / NI;
  localparam int N   = NC * IS;
  localparam int IB  = G * IS;
  localparam int OB  = (N + OW - 1) / OW;
  localparam int POW = 5;
  localparam int POB = (N + POW - 1) / POW;
  localparam int W   = OW * BS + 2;

  // clock / reset
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  // main DUT (defaults: channel-major, OutWidth 4)
  logic                 in_valid, in_start, in_ready;
  logic [NI*BS-1:0]     in_data;
  logic                 out_valid, out_ready, out_start, out_last, frame_abort;
  logic [OW*BS-1:0]     out_data;

  flattening_stream u_dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_start(in_start),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_start(out_start), .out_last(out_last),
    .out_data(out_data), .frame_abort(frame_abort)
  );

  // padding DUT (OutWidth 5, pixel-major)
  logic                 p_in_valid, p_in_start, p_in_ready;
  logic [NI*BS-1:0]     p_in_data;
  logic                 p_out_valid, p_out_ready, p_out_start, p_out_last, p_frame_abort;
  logic [POW*BS-1:0]    p_out_data;

  flattening_stream #(.OutWidth(POW), .Interleave(1)) u_pad (
    .clk(clk), .res(res), .in_valid(p_in_valid), .in_start(p_in_start),
    .in_data(p_in_data), .in_ready(p_in_ready), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .out_start(p_out_start), .out_last(p_out_last),
    .out_data(p_out_data), .frame_abort(p_frame_abort)
  );

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;   // 0: out_ready low, 1: high, 2: random
  int beats_out = 0;
  int aborts    = 0;
  logic [W-1:0]  exp_q[$];
  logic [BS-1:0] pix [NC][IS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // scoreboard / monitor for the main DUT
  logic [W-1:0] prev_beat;
  logic prev_stall = 1'b0;
  logic prev_abort = 1'b0;
  always @(negedge clk) begin
    if (!res) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'({out_last, out_start, out_data}), 32'(prev_beat));
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL beat_extra: observed=%0h expected=no beat", {out_last, out_start, out_data});
        end
        if (exp_q.size() > 0)
          check("beat", 32'({out_last, out_start, out_data}), 32'(exp_q.pop_front()));
        beats_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_start, out_data};
      if (frame_abort) begin
        aborts++;
        check("abort_width", 32'(prev_abort), 32'd0);
      end
      prev_abort = frame_abort;
    end else begin
      prev_stall = 1'b0;
      prev_abort = 1'b0;
    end
  end

  // reference model: flatten channel-major, chunk into OW-element beats, pad with 0
  task automatic push_expected();
    logic [BS-1:0]    flat [N];
    logic [OW*BS-1:0] d;
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < IS; p++)
        flat[c*IS + p] = pix[c][p];
    for (int b = 0; b < OB; b++) begin
      d = '0;
      for (int j = 0; j < OW; j++)
        if (b*OW + j < N) d[j*BS +: BS] = flat[b*OW + j];
      exp_q.push_back({(b == OB-1), (b == 0), d});
    end
  endtask

  // drive one frame; abort_at > 0 sends that many beats of a throwaway frame first
  task automatic send_frame(input int mode, input int abort_at);
    logic [NI*BS-1:0] d;
    logic acc;
    int i, g, p;
    for (int c = 0; c < NC; c++)
      for (int q = 0; q < IS; q++)
        pix[c][q] = (mode == 1) ? BS'((c + q) % 4) : BS'($urandom_range(0, 3));
    @(posedge clk); #1;
    for (int b = 0; b < abort_at + IB; b++) begin
      if (b < abort_at) begin
        d = (NI*BS)'($urandom);
        in_start = (b == 0);
      end else begin
        i = b - abort_at;
        g = i / IS;
        p = i % IS;
        for (int l = 0; l < NI; l++) d[l*BS +: BS] = pix[g*NI + l][p];
        in_start = (i == 0);
      end
      in_valid = 1'b1;
      in_data  = d;
      acc = 1'b0;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: observed=in_ready stuck low expected=beat %0d accepted", b);
        in_valid = 1'b0;
        in_start = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_start = 1'b0;
    push_expected();
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 5000 && exp_q.size() > 0; t++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // single pixel-major frame through the padding DUT, checked beat by beat
  task automatic pad_frame();
    logic [BS-1:0]     flat [N];
    logic [POW*BS-1:0] e;
    logic [POW*BS-1:0] got [$];
    logic [1:0]        flg [$];
    logic done;
    for (int c = 0; c < NC; c++)
      for (int q = 0; q < IS; q++) begin
        pix[c][q] = BS'($urandom_range(0, 3));
        flat[q*NC + c] = pix[c][q];
      end
    p_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < IB; i++) begin
      p_in_valid = 1'b1;
      p_in_start = (i == 0);
      for (int l = 0; l < NI; l++) p_in_data[l*BS +: BS] = pix[(i / IS)*NI + l][i % IS];
      @(negedge clk);
      check("pad_in_ready", 32'(p_in_ready), 32'd1);
      @(posedge clk); #1;
    end
    p_in_valid = 1'b0;
    p_in_start = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (p_out_valid) begin
        got.push_back(p_out_data);
        flg.push_back({p_out_last, p_out_start});
        done = p_out_last;
      end
    end
    check("pad_beats", 32'(got.size()), 32'(POB));
    if (got.size() == POB) begin
      for (int b = 0; b < POB; b++) begin
        e = '0;
        for (int j = 0; j < POW; j++)
          if (b*POW + j < N) e[j*BS +: BS] = flat[b*POW + j];
        check("pad_beat", 32'(got[b]), 32'(e));
        check("pad_flags", 32'(flg[b]), {30'd0, (b == POB-1), (b == 0)});
      end
      check("pad_beat0", 32'(got[0]), 32'({pix[0][1], pix[3][0], pix[2][0], pix[1][0], pix[0][0]}));
      check("pad_beat7", 32'(got[POB-1]), 32'({8'd0, pix[3][8]}));
    end
    @(negedge clk);
    check("pad_idle", 32'(p_out_valid), 32'd0);
  endtask

  initial begin
    int b0, a0;
    logic found;
    res = 1'b1;
    in_valid = 1'b0; in_start = 1'b0; in_data = '0;
    p_in_valid = 1'b0; p_in_start = 1'b0; p_in_data = '0; p_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_start", 32'(out_start), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    res = 1'b0;

    // single channel-major frame with the (c+p)%4 pattern
    rdy_mode = 1;
    b0 = beats_out;
    send_frame(1, 0);
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("first_start", 32'(out_start), 32'd1);
    check("first_data", 32'(out_data), 32'h0e4);
    wait_drain();
    check("frame1_beats", 32'(beats_out - b0), 32'(OB));

    // padding with OutWidth 5, pixel-major
    pad_frame();

    // double buffering under backpressure
    rdy_mode = 0;
    @(posedge clk);
    send_frame(0, 0);
    send_frame(0, 0);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    found = 1'b0;
    fork
      send_frame(0, 0);
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 1;
        for (int t = 0; t < 100 && !found; t++) begin
          @(negedge clk);
          if (out_valid && out_ready && out_last) begin
            found = 1'b1;
            check("rise_before", 32'(in_ready), 32'd0);
            @(negedge clk);
            check("rise_after", 32'(in_ready), 32'd1);
          end
        end
        check("first_last_seen", 32'(found), 32'd1);
      end
    join
    wait_drain();

    // random stalls across 4 frames
    rdy_mode = 2;
    b0 = beats_out;
    repeat (4) send_frame(0, 0);
    wait_drain();
    check("stall_beats", 32'(beats_out - b0), 32'(4*OB));

    // abort: in_start on beat 7 restarts the frame
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    a0 = aborts;
    b0 = beats_out;
    send_frame(0, 7);
    @(negedge clk);
    check("abort_latency", 32'(out_valid), 32'd1);
    wait_drain();
    check("abort_count", 32'(aborts - a0), 32'd1);
    check("abort_beats", 32'(beats_out - b0), 32'(OB));

    // reset during output beat 4
    repeat (3) @(posedge clk);
    b0 = beats_out;
    send_frame(0, 0);
    for (int t = 0; t < 100 && (beats_out - b0) < 4; t++) @(posedge clk);
    #1;
    check("pre_reset_beat", 32'(beats_out - b0), 32'd4);
    res = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_start", 32'(out_start), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    res = 1'b0;
    b0 = beats_out;
    send_frame(0, 0);
    @(negedge clk);
    check("post_rst_start", 32'(out_start), 32'd1);
    wait_drain();
    check("post_rst_beats", 32'(beats_out - b0), 32'(OB));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
